// File: rtl/trace_output_buffer.sv
// Trace record FIFO between the tracer and the trace consumer, with drop accounting.
// Optional end-of-program stop detection is enabled by defining TRACE_STOP_ADDR_EN.
module trace_output_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = 64,
    parameter logic [31:0] STOP_ADDR = 32'h54
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          capture_en_i,
    input  logic                          trace_valid_i,
    input  logic [31:0]                   trace_addr_i,
    input  logic [DATA_W-1:0]             trace_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [32+DATA_W-1:0]          out_data_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_count_o,
    output logic                          done_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned ENT_W = 32 + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] level_q;
    logic [PTR_W-1:0] level_next;
    logic             valid_q;
    logic             overflow_q;
    logic [15:0]      drop_count_q;

    logic full_c;
    logic capture_c;
    logic cand_c;
    logic push_c;
    logic pop_c;
    logic drop_c;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cand_c    = trace_valid_i && capture_en_i && capture_c;
    assign pop_c     = valid_q && out_ready_i;
    assign push_c    = cand_c && (!full_c || pop_c);
    assign drop_c    = cand_c && full_c && !pop_c;

    always_comb begin
        level_next = level_q;
        if (push_c && !pop_c) begin
            level_next = level_q + PTR_W'(1);
        end else if (pop_c && !push_c) begin
            level_next = level_q - PTR_W'(1);
        end
    end

    // Storage is written only; never reset.
    always_ff @(posedge clk) begin
        if (push_c && !clear_i) begin
            mem[wr_ptr_q[AW-1:0]] <= {trace_addr_i, trace_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_next;
            valid_q <= (level_next != '0);
            if (drop_c) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

`ifdef TRACE_STOP_ADDR_EN
    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

    state_t state_q;
    logic   done_q;

    // A stop-address record ends capture whether it was stored or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAPTURE;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= CAPTURE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (cand_c && (trace_addr_i == STOP_ADDR)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level_next == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= CAPTURE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign capture_c = (state_q == CAPTURE);
    assign done_o    = done_q;
`else
    logic unused_stop_addr;

    assign unused_stop_addr = ^STOP_ADDR;
    assign capture_c        = 1'b1;
    assign done_o           = 1'b0;
`endif

    assign out_valid_o  = valid_q;
    assign out_data_o   = mem[rd_ptr_q[AW-1:0]];
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_trace_output_buffer.sv
// Directed checks for trace_output_buffer: vector table plus hand-written
// sequences for overflow, full push/pop, stop detection and async reset.
module tb_trace_output_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 64;

    logic                 clk;
    logic                 rst_n;
    logic                 clear_i;
    logic                 capture_en_i;
    logic                 trace_valid_i;
    logic [31:0]          trace_addr_i;
    logic [DATA_W-1:0]    trace_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [32+DATA_W-1:0] out_data_o;
    logic [4:0]           level_o;
    logic                 overflow_o;
    logic [15:0]          drop_count_o;
    logic                 done_o;

    int n_tests;
    int n_fail;

    trace_output_buffer #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .STOP_ADDR(32'h54)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .capture_en_i (capture_en_i),
        .trace_valid_i(trace_valid_i),
        .trace_addr_i (trace_addr_i),
        .trace_data_i (trace_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        en;
        logic        vld;
        logic [31:0] addr;
        logic        rdy;
        logic        e_valid;
        logic [4:0]  e_level;
        logic [31:0] e_addr;
        logic [15:0] e_drop;
        logic        e_ovf;
    } vec_t;

    function automatic logic [DATA_W-1:0] mkdata(input logic [31:0] a);
        return {32'hDA7A0000, a};
    endfunction

    function automatic logic [95:0] mkent(input logic [31:0] a);
        return {a, mkdata(a)};
    endfunction

    function automatic vec_t mk(input logic clr, input logic en, input logic vld,
                                input logic [31:0] addr, input logic rdy,
                                input logic e_valid, input logic [4:0] e_level,
                                input logic [31:0] e_addr, input logic [15:0] e_drop,
                                input logic e_ovf);
        vec_t v;
        v.clr = clr; v.en = en; v.vld = vld; v.addr = addr; v.rdy = rdy;
        v.e_valid = e_valid; v.e_level = e_level; v.e_addr = e_addr;
        v.e_drop = e_drop; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic en, input logic vld,
                         input logic [31:0] addr, input logic rdy);
        clear_i       = clr;
        capture_en_i  = en;
        trace_valid_i = vld;
        trace_addr_i  = addr;
        trace_data_i  = mkdata(addr);
        out_ready_i   = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    vec_t vecs[12];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = mk(0, 1, 1, 32'h20, 0, 1, 5'd1, 32'h20, 16'd0, 0);
        vecs[1]  = mk(0, 1, 1, 32'h24, 0, 1, 5'd2, 32'h20, 16'd0, 0);
        vecs[2]  = mk(0, 1, 1, 32'h28, 0, 1, 5'd3, 32'h20, 16'd0, 0);
        vecs[3]  = mk(0, 1, 0, 32'h0,  0, 1, 5'd3, 32'h20, 16'd0, 0);
        vecs[4]  = mk(0, 1, 0, 32'h0,  1, 1, 5'd2, 32'h24, 16'd0, 0);
        vecs[5]  = mk(0, 1, 0, 32'h0,  1, 1, 5'd1, 32'h28, 16'd0, 0);
        vecs[6]  = mk(0, 1, 1, 32'h2C, 1, 1, 5'd1, 32'h2C, 16'd0, 0);
        vecs[7]  = mk(0, 1, 0, 32'h0,  1, 0, 5'd0, 32'h0,  16'd0, 0);
        vecs[8]  = mk(0, 0, 1, 32'h30, 1, 0, 5'd0, 32'h0,  16'd0, 0);
        vecs[9]  = mk(0, 1, 1, 32'h34, 1, 1, 5'd1, 32'h34, 16'd0, 0);
        vecs[10] = mk(0, 1, 1, 32'h38, 0, 1, 5'd2, 32'h34, 16'd0, 0);
        vecs[11] = mk(1, 1, 1, 32'h3C, 1, 0, 5'd0, 32'h0,  16'd0, 0);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 128'(out_valid_o), 128'(0));
        check("rst_level", 128'(level_o), 128'(0));
        check("rst_ovf", 128'(overflow_o), 128'(0));
        check("rst_drop", 128'(drop_count_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ordering, hold, push/pop at level 1, ignore when disabled, clear priority.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].vld, vecs[i].addr, vecs[i].rdy);
            step();
            check($sformatf("v%0d_valid", i), 128'(out_valid_o), 128'(vecs[i].e_valid));
            check($sformatf("v%0d_level", i), 128'(level_o), 128'(vecs[i].e_level));
            check($sformatf("v%0d_drop", i), 128'(drop_count_o), 128'(vecs[i].e_drop));
            check($sformatf("v%0d_ovf", i), 128'(overflow_o), 128'(vecs[i].e_ovf));
            if (vecs[i].e_valid)
                check($sformatf("v%0d_data", i), 128'(out_data_o), 128'(mkent(vecs[i].e_addr)));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Overflow: 20 pushes into 16 entries, no same-cycle bypass on first push.
        do_clear();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b0);
            if (i == 0) begin
                #1;
                check("no_bypass", 128'(out_valid_o), 128'(0));
            end
            step();
        end
        check("ovf_level", 128'(level_o), 128'(16));
        check("ovf_drop", 128'(drop_count_o), 128'(4));
        check("ovf_flag", 128'(overflow_o), 128'(1));
        check("ovf_head", 128'(out_data_o), 128'(mkent(32'h100)));

        // Push and pop together while full.
        drive(1'b0, 1'b1, 1'b1, 32'h900, 1'b1);
        step();
        check("full_pp_level", 128'(level_o), 128'(16));
        check("full_pp_drop", 128'(drop_count_o), 128'(4));
        check("full_pp_head", 128'(out_data_o), 128'(mkent(32'h104)));

        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ea;
            ea = (i < 15) ? 32'h104 + 32'(4 * i) : 32'h900;
            check($sformatf("drain%0d_valid", i), 128'(out_valid_o), 128'(1));
            check($sformatf("drain%0d_data", i), 128'(out_data_o), 128'(mkent(ea)));
            step();
        end
        check("drain_empty", 128'(out_valid_o), 128'(0));
        check("drain_level", 128'(level_o), 128'(0));

        do_clear();
        check("clr_drop", 128'(drop_count_o), 128'(0));
        check("clr_ovf", 128'(overflow_o), 128'(0));

`ifdef TRACE_STOP_ADDR_EN
        drive(1'b0, 1'b1, 1'b1, 32'h50, 1'b0); step();
        drive(1'b0, 1'b1, 1'b1, 32'h54, 1'b0); step();
        drive(1'b0, 1'b1, 1'b1, 32'h58, 1'b0); step();
        check("stop_level", 128'(level_o), 128'(2));
        check("stop_done0", 128'(done_o), 128'(0));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); step();
        check("stop_head", 128'(out_data_o), 128'(mkent(32'h54)));
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("stop_done1", 128'(done_o), 128'(1));
        check("stop_empty", 128'(level_o), 128'(0));
        drive(1'b0, 1'b1, 1'b1, 32'h60, 1'b0); step();
        check("done_ignore", 128'(level_o), 128'(0));
        check("done_hold", 128'(done_o), 128'(1));
        do_clear();
        check("clr_done", 128'(done_o), 128'(0));
        check("clr_level", 128'(level_o), 128'(0));
        drive(1'b0, 1'b1, 1'b1, 32'h64, 1'b0); step();
        check("recapture", 128'(level_o), 128'(1));
`else
        drive(1'b0, 1'b1, 1'b1, 32'h54, 1'b0); step();
        drive(1'b0, 1'b1, 1'b1, 32'h58, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        check("nostop_level", 128'(level_o), 128'(2));
        check("nostop_done", 128'(done_o), 128'(0));
        check("nostop_head", 128'(out_data_o), 128'(mkent(32'h54)));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); step();
        check("nostop_second", 128'(out_data_o), 128'(mkent(32'h58)));
`endif

        // Asynchronous reset mid-drain at level 5.
        do_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        check("pre_rst_level", 128'(level_o), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(out_valid_o), 128'(0));
        check("arst_level", 128'(level_o), 128'(0));
        check("arst_drop", 128'(drop_count_o), 128'(0));
        check("arst_done", 128'(done_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_output_buffer.md
TRACE_OUTPUT_BUFFER -- requirements
Module: trace_output_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 The block SHALL have parameter DATA_W, default 64, width of trace payload excluding address.
REQ-003 The block SHALL have parameter STOP_ADDR, default 32'h54, end-of-program instruction address.
REQ-004 Ports SHALL be:
  clk  input  1  single clock, all logic rising-edge
  rst_n  input  1  asynchronous active-low reset
  clear_i  input  1  synchronous flush of FIFO, counters, state
  capture_en_i  input  1  accept trace records when high
  trace_valid_i  input  1  one trace record presented this cycle (from gouram tracer)
  trace_addr_i  input  32  instruction address of record
  trace_data_i  input  DATA_W  remaining trace record fields
  out_valid_o  output  1  head entry available
  out_ready_i  input  1  consumer accepts head entry
  out_data_o  output  32+DATA_W  {addr, data} of head entry
  level_o  output  $clog2(DEPTH)+1  current occupancy
  overflow_o  output  1  sticky: at least one record dropped
  drop_count_o  output  16  records dropped, saturating
  done_o  output  1  capture finished and drained

Function
REQ-005 A record SHALL be pushed when trace_valid_i && capture_en_i && state==CAPTURE && (!full || pop this cycle).
REQ-006 A pop SHALL occur when out_valid_o && out_ready_i.
REQ-007 out_valid_o SHALL equal !empty; out_data_o SHALL present the oldest entry, stable while out_valid_o && !out_ready_i.
REQ-008 Push-to-out_valid_o latency SHALL be 1 cycle when empty (no same-cycle bypass).
REQ-009 Simultaneous push and pop SHALL leave level_o unchanged, including at full and at level 1.
REQ-010 Read/write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ, low bits equal.
REQ-011 A record meeting REQ-005 conditions except for fullness SHALL be dropped: overflow_o set, drop_count_o +1, saturating at 16'hFFFF.
REQ-012 Records arriving with capture_en_i low or state!=CAPTURE SHALL be ignored without counting as drops.
REQ-013 clear_i SHALL empty the FIFO, zero drop_count_o, clear overflow_o, return state to CAPTURE; clear_i has priority over push/pop in the same cycle.

Reset
REQ-014 On rst_n low, asynchronously: pointers 0, out_valid_o 0, level_o 0, overflow_o 0, drop_count_o 0, done_o 0, state CAPTURE.
REQ-015 Reset mid-transfer SHALL discard all stored entries; out_data_o content is don't-care while out_valid_o is 0.
REQ-016 FIFO storage SHALL NOT require reset.

Configuration
REQ-017 Macro TRACE_STOP_ADDR_EN SHALL gate the stop-detection state machine.
REQ-018 With TRACE_STOP_ADDR_EN defined: states CAPTURE, DRAIN, DONE; CAPTURE->DRAIN on a pushed record whose addr==STOP_ADDR (record itself stored); a dropped STOP_ADDR record also transitions, the drop counted; DRAIN->DONE when empty; DONE holds until clear_i or reset; done_o = (state==DONE).
REQ-019 Without TRACE_STOP_ADDR_EN: state permanently CAPTURE, done_o tied 0, STOP_ADDR unused.

Verification
REQ-020 Push addrs 0x20,0x24,0x28 with out_ready_i=0 -> level_o=3, out_valid_o high from cycle after first push, out_data_o addr 0x20 held; then out_ready_i=1 -> addrs emerge 0x20,0x24,0x28 in order.
REQ-021 DEPTH=16, 20 back-to-back pushes, out_ready_i=0 -> level_o=16, drop_count_o=4, overflow_o=1; drain yields first 16 records.
REQ-022 Full FIFO, push and pop same cycle -> level_o stays 16, drop_count_o unchanged, new record appears last on drain.
REQ-023 TRACE_STOP_ADDR_EN defined, push 0x50,0x54,0x58 -> 0x58 ignored, state DRAIN; after two pops done_o=1; clear_i -> done_o=0, level_o=0.
REQ-024 Assert rst_n low with level_o=5 mid-drain -> out_valid_o, level_o, drop_count_o read 0 immediately, before next clk edge.
REQ-025 Without TRACE_STOP_ADDR_EN, push 0x54 then 0x58 -> both stored, done_o remains 0.
